// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module      : morse_pkg
// Description : Symbol codes shared by the Morse classifier, letter controller
//               and decoder, plus the letter-controller state encoding.
// Revision    : 1.0
// ============================================================================
package morse_pkg;

    localparam logic [1:0] c_SYM_GAP  = 2'b00;
    localparam logic [1:0] c_SYM_DOT  = 2'b01;
    localparam logic [1:0] c_SYM_DASH = 2'b10;
    localparam logic [1:0] c_SYM_STOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_EMIT    = 2'b10
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/morse_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : morse_gap_timer
// Description : Tick-driven saturating idle counter that signals when a letter
//               has been quiet for TIMEOUT ticks.
// Revision    : 1.0
// ============================================================================
module morse_gap_timer #(
    parameter int TIMEOUT = 8
) (
    input  logic clk_board,
    input  logic clear,
    input  logic tick,
    input  logic restart,
    input  logic run,
    output logic expired
);

    localparam logic [7:0] c_LIMIT = 8'(TIMEOUT);
    localparam logic [7:0] c_LAST  = 8'(TIMEOUT - 1);

    logic [7:0] r_idle_ticks;

    always_ff @(posedge clk_board or negedge clear) begin
        if (!clear) begin
            r_idle_ticks <= '0;
        end else if (restart) begin
            r_idle_ticks <= '0;
        end else if (run && tick && (r_idle_ticks != c_LIMIT)) begin
            r_idle_ticks <= r_idle_ticks + 8'd1;
        end
    end

    // Look ahead at the tick that is about to saturate so the letter closes on
    // the same edge that the final tick is sampled.
    assign expired = (r_idle_ticks == c_LIMIT) ||
                     (run && tick && (r_idle_ticks == c_LAST));

endmodule
`default_nettype wire

// File: rtl/morse_letter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : morse_letter_ctrl
// Description : Assembles DOT/DASH symbols into a letter code and hands it
//               downstream over a valid/ready handshake.
// Revision    : 1.0
// ============================================================================
module morse_letter_ctrl
    import morse_pkg::*;
#(
    parameter int MAX_SYM = 5,
    parameter int TIMEOUT = 8
) (
    input  logic               clk_board,
    input  logic               clear,
    input  logic               tick,
    input  logic [1:0]         sym_type,
    input  logic               auto_gap_en,
    input  logic               code_ready,
    output logic               code_valid,
    output logic [2:0]         code_len,
    output logic [MAX_SYM-1:0] code_bits,
    output logic               code_err,
    output logic               drop,
    output logic               busy
);

    localparam logic [2:0] c_MAX_LEN = 3'(MAX_SYM);

    ctrl_state_t        r_state;
    logic [2:0]         r_len;
    logic [MAX_SYM-1:0] r_bits;
    logic               r_err;
    logic               r_valid;
    logic               r_drop;
    logic               r_busy;

    logic               w_is_mark;
    logic               w_is_dash;
    logic               w_is_gap;
    logic               w_expired;
    logic               w_restart;
    logic [MAX_SYM-1:0] w_first_bits;

    assign w_is_dash = (sym_type == c_SYM_DASH);
    assign w_is_mark = (sym_type == c_SYM_DOT) || w_is_dash;
    assign w_is_gap  = (sym_type == c_SYM_GAP);

    // Holding the counter cleared outside COLLECT makes every entry start at 0.
    assign w_restart = w_is_mark || (r_state != ST_COLLECT);

    always_comb begin
        w_first_bits    = '0;
        w_first_bits[0] = w_is_dash;
    end

    morse_gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk_board (clk_board),
        .clear     (clear),
        .tick      (tick),
        .restart   (w_restart),
        .run       (r_state == ST_COLLECT),
        .expired   (w_expired)
    );

    always_ff @(posedge clk_board or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_bits  <= '0;
            r_err   <= 1'b0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_drop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_is_mark) begin
                        r_bits  <= w_first_bits;
                        r_len   <= 3'd1;
                        r_err   <= 1'b0;
                        r_state <= ST_COLLECT;
                        r_busy  <= 1'b1;
                    end else if (w_is_gap) begin
                        r_bits  <= '0;
                        r_len   <= 3'd0;
                        r_err   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= ST_EMIT;
                        r_busy  <= 1'b1;
                    end
                end

                ST_COLLECT: begin
                    if (w_is_mark) begin
                        if (r_len < c_MAX_LEN) begin
                            for (int i = 0; i < MAX_SYM; i++) begin
                                if (r_len == 3'(i)) begin
                                    r_bits[i] <= w_is_dash;
                                end
                            end
                            r_len <= r_len + 3'd1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (w_is_gap || (auto_gap_en && w_expired)) begin
                        r_valid <= 1'b1;
                        r_state <= ST_EMIT;
                    end
                end

                ST_EMIT: begin
                    if (code_ready) begin
                        r_valid <= 1'b0;
                        if (w_is_mark) begin
                            r_bits  <= w_first_bits;
                            r_len   <= 3'd1;
                            r_err   <= 1'b0;
                            r_state <= ST_COLLECT;
                        end else begin
                            // A GAP arriving with the accept has no letter to close.
                            r_drop  <= w_is_gap;
                            r_bits  <= '0;
                            r_len   <= 3'd0;
                            r_err   <= 1'b0;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (sym_type != c_SYM_STOP) begin
                        r_drop <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign code_valid = r_valid;
    assign code_len   = r_len;
    assign code_bits  = r_bits;
    assign code_err   = r_err;
    assign drop       = r_drop;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_morse_letter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_morse_letter_ctrl
// Description : Directed self-checking bench for morse_letter_ctrl.
// Revision    : 1.0
// ============================================================================
module tb_morse_letter_ctrl;

    localparam int MAX_SYM = 5;
    localparam int TIMEOUT = 8;

    localparam logic [1:0] c_GAP  = 2'b00;
    localparam logic [1:0] c_DOT  = 2'b01;
    localparam logic [1:0] c_DASH = 2'b10;
    localparam logic [1:0] c_STOP = 2'b11;

    logic               clk_board = 1'b0;
    logic               clear;
    logic               tick;
    logic [1:0]         sym_type;
    logic               auto_gap_en;
    logic               code_ready;
    logic               code_valid;
    logic [2:0]         code_len;
    logic [MAX_SYM-1:0] code_bits;
    logic               code_err;
    logic               drop;
    logic               busy;

    int errors = 0;
    int checks = 0;

    morse_letter_ctrl #(
        .MAX_SYM (MAX_SYM),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_board   (clk_board),
        .clear       (clear),
        .tick        (tick),
        .sym_type    (sym_type),
        .auto_gap_en (auto_gap_en),
        .code_ready  (code_ready),
        .code_valid  (code_valid),
        .code_len    (code_len),
        .code_bits   (code_bits),
        .code_err    (code_err),
        .drop        (drop),
        .busy        (busy)
    );

    always #5 clk_board = ~clk_board;

    task automatic step();
        @(posedge clk_board);
        #1;
    endtask

    task automatic send(input logic [1:0] s);
        sym_type = s;
        step();
        sym_type = c_STOP;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #3;
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", code_valid); end
        checks++; if (code_len !== 3'd0) begin errors++; $display("FAIL reset_len: got %0d want 0", code_len); end
        checks++; if (code_bits !== 5'b00000) begin errors++; $display("FAIL reset_bits: got %b want 00000", code_bits); end
        checks++; if ({code_err, drop, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {code_err, drop, busy}); end
        step();
        clear = 1'b1;
        step();
    endtask

    task automatic test_basic_letter();
        code_ready = 1'b1;
        send(c_DASH);
        checks++; if ({busy, code_valid, code_len} !== {1'b1, 1'b0, 3'd1}) begin errors++; $display("FAIL basic_first: got busy/valid/len %b/%b/%0d want 1/0/1", busy, code_valid, code_len); end
        send(c_DOT);
        send(c_DOT);
        send(c_GAP);
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", code_valid); end
        checks++; if (code_len !== 3'd3) begin errors++; $display("FAIL basic_len: got %0d want 3", code_len); end
        checks++; if (code_bits !== 5'b00001) begin errors++; $display("FAIL basic_bits: got %b want 00001", code_bits); end
        checks++; if (code_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", code_err); end
        step();
        checks++; if ({code_valid, busy, code_len, code_bits} !== {1'b0, 1'b0, 3'd0, 5'b0}) begin errors++; $display("FAIL basic_after: got valid/busy/len/bits %b/%b/%0d/%b want 0/0/0/00000", code_valid, busy, code_len, code_bits); end
    endtask

    task automatic test_overflow();
        code_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            send(c_DOT);
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL ovf_drop%0d: got %b want 0", i, drop); end
        end
        send(c_GAP);
        checks++; if ({code_valid, code_len, code_bits, code_err} !== {1'b1, 3'd5, 5'b00000, 1'b1}) begin errors++; $display("FAIL ovf_code: got valid/len/bits/err %b/%0d/%b/%b want 1/5/00000/1", code_valid, code_len, code_bits, code_err); end
        code_ready = 1'b1;
        step();
        code_ready = 1'b0;
        checks++; if ({code_valid, code_err, busy} !== 3'b000) begin errors++; $display("FAIL ovf_accept: got valid/err/busy %b%b%b want 000", code_valid, code_err, busy); end
    endtask

    task automatic test_timeout();
        auto_gap_en = 1'b1;
        send(c_DOT);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            pulse_tick();
            step();
        end
        checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", code_valid); end
        pulse_tick();
        checks++; if ({code_valid, code_len, code_bits} !== {1'b1, 3'd1, 5'b0}) begin errors++; $display("FAIL to_close: got valid/len/bits %b/%0d/%b want 1/1/00000", code_valid, code_len, code_bits); end
        code_ready = 1'b1;
        step();
        code_ready = 1'b0;
        auto_gap_en = 1'b0;
        send(c_DOT);
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            pulse_tick();
        end
        checks++; if ({code_valid, busy} !== 2'b01) begin errors++; $display("FAIL to_disabled: got valid/busy %b%b want 01", code_valid, busy); end
        auto_gap_en = 1'b1;
        step();
        checks++; if ({code_valid, code_len} !== {1'b1, 3'd1}) begin errors++; $display("FAIL to_late_enable: got valid/len %b/%0d want 1/1", code_valid, code_len); end
        code_ready = 1'b1;
        step();
        code_ready = 1'b0;
        auto_gap_en = 1'b0;
    endtask

    task automatic test_backpressure();
        int drops;
        drops = 0;
        code_ready = 1'b0;
        send(c_DOT);
        send(c_GAP);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) sym_type = c_DASH;
            else if (i == 6) sym_type = c_GAP;
            else sym_type = c_STOP;
            step();
            sym_type = c_STOP;
            if (drop === 1'b1) drops++;
            checks++; if ({code_valid, code_len, code_bits} !== {1'b1, 3'd1, 5'b0}) begin errors++; $display("FAIL bp_hold%0d: got valid/len/bits %b/%0d/%b want 1/1/00000", i, code_valid, code_len, code_bits); end
        end
        checks++; if (drops !== 2) begin errors++; $display("FAIL bp_drops: got %0d want 2", drops); end
        code_ready = 1'b1;
        send(c_DASH);
        code_ready = 1'b0;
        checks++; if ({code_valid, busy, code_len, code_bits[0], drop} !== {1'b0, 1'b1, 3'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL bp_restart: got valid/busy/len/bit0/drop %b/%b/%0d/%b/%b want 0/1/1/1/0", code_valid, busy, code_len, code_bits[0], drop); end
        send(c_GAP);
        checks++; if ({code_valid, code_len, code_bits} !== {1'b1, 3'd1, 5'b00001}) begin errors++; $display("FAIL bp_letter: got valid/len/bits %b/%0d/%b want 1/1/00001", code_valid, code_len, code_bits); end
        code_ready = 1'b1;
        send(c_GAP);
        code_ready = 1'b0;
        checks++; if ({code_valid, busy, drop} !== 3'b001) begin errors++; $display("FAIL bp_gap_accept: got valid/busy/drop %b%b%b want 001", code_valid, busy, drop); end
        step();
    endtask

    task automatic test_word_space_and_clear();
        send(c_GAP);
        checks++; if ({code_valid, code_len, busy} !== {1'b1, 3'd0, 1'b1}) begin errors++; $display("FAIL ws_code: got valid/len/busy %b/%0d/%b want 1/0/1", code_valid, code_len, busy); end
        code_ready = 1'b1;
        step();
        code_ready = 1'b0;
        send(c_DASH);
        send(c_DASH);
        #2;
        clear = 1'b0;
        #1;
        checks++; if ({code_valid, code_len, code_bits, code_err, drop, busy} !== 12'b0) begin errors++; $display("FAIL clr_outputs: got valid/len/bits/err/drop/busy %b/%0d/%b/%b/%b/%b want all 0", code_valid, code_len, code_bits, code_err, drop, busy); end
        step();
        clear = 1'b1;
        send(c_DOT);
        send(c_GAP);
        checks++; if ({code_valid, code_len, code_bits, code_err} !== {1'b1, 3'd1, 5'b0, 1'b0}) begin errors++; $display("FAIL clr_clean: got valid/len/bits/err %b/%0d/%b/%b want 1/1/00000/0", code_valid, code_len, code_bits, code_err); end
        code_ready = 1'b1;
        step();
        code_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        code_ready = 1'b1;
        send(c_DOT);
        send(c_GAP);
        checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid1: got %b want 1", code_valid); end
        send(c_DASH);
        checks++; if ({code_valid, busy, code_len, code_bits} !== {1'b0, 1'b1, 3'd1, 5'b00001}) begin errors++; $display("FAIL b2b_restart: got valid/busy/len/bits %b/%b/%0d/%b want 0/1/1/00001", code_valid, busy, code_len, code_bits); end
        send(c_DOT);
        send(c_GAP);
        checks++; if ({code_valid, code_len, code_bits} !== {1'b1, 3'd2, 5'b00001}) begin errors++; $display("FAIL b2b_letter2: got valid/len/bits %b/%0d/%b want 1/2/00001", code_valid, code_len, code_bits); end
        step();
        checks++; if ({code_valid, busy} !== 2'b00) begin errors++; $display("FAIL b2b_idle: got valid/busy %b%b want 00", code_valid, busy); end
        code_ready = 1'b0;
    endtask

    initial begin
        clear       = 1'b1;
        tick        = 1'b0;
        sym_type    = c_STOP;
        auto_gap_en = 1'b0;
        code_ready  = 1'b0;
        #2;
        test_reset();
        test_basic_letter();
        test_overflow();
        test_timeout();
        test_backpressure();
        test_word_space_and_clear();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_letter_ctrl.md
# morse_letter_ctrl

Collects the per-symbol classifications (DOT/DASH/GAP/STOP) produced by the Morse key classifier into one letter code and hands it downstream to the letter decoder/display over a valid/ready handshake. It sequences the symbol stream:

- accumulates up to MAX_SYM symbols;
- closes a letter on GAP or on an inactivity timeout;
- flags overflow;
- drops symbols while a letter is waiting for acceptance.

## Interface

Parameters:

- MAX_SYM, 5: maximum symbols per letter. Legal range 1..7.
- TIMEOUT, 8: number of tick pulses without a symbol that auto-closes a letter. Legal range 1..255.

Ports:

- clk_board  in  1  system clock. Single clock domain. All outputs are registered.
- clear  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle enable pulse at the slow key-sampling rate.
- sym_type  in  2  classifier output: GAP=00, DOT=01, DASH=10, STOP=11. A non-STOP value is present for exactly one clk_board cycle per event.
- auto_gap_en  in  1  enables the timeout auto-close.
- code_ready  in  1  downstream accepts the code.
- code_valid  out  1  letter code available.
- code_len  out  3  number of symbols, 0..MAX_SYM. 0 means word space.
- code_bits  out  MAX_SYM  symbol i in bit i, with the first symbol in bit 0. 1 = DASH, 0 = DOT. Bits at index ≥ code_len are 0.
- code_err  out  1  letter overflowed MAX_SYM. Qualified by code_valid.
- drop  out  1  one-cycle pulse: an input event was discarded.
- busy  out  1  state ≠ IDLE.

## Operation

States:

- IDLE
  - DOT/DASH: write bit 0, set len=1, go to COLLECT.
  - GAP: load len=0, bits=0, err=0, go to EMIT (word space).
- COLLECT
  - DOT/DASH with len<MAX_SYM: write bit[len], len+1.
  - DOT/DASH with len==MAX_SYM: set sticky err. len and bits are unchanged.
  - GAP, or timeout while auto_gap_en=1: go to EMIT.
- EMIT
  - code_valid=1. code_len, code_bits and code_err are held stable.
  - On code_valid&&code_ready, the transfer completes.
    - Same cycle DOT/DASH: it becomes symbol 0 of a new letter, go to COLLECT with len=1.
    - Same cycle GAP: drop pulse, go to IDLE.
    - Otherwise: go to IDLE.
  - Without the handshake, any non-STOP input is discarded and drop pulses.

STOP is a no-op in every state.

Timeout counter (idle_ticks):

- Cleared on entry to COLLECT and on every accepted or overflowed DOT/DASH.
- Increments on tick while in COLLECT. Saturates at TIMEOUT.
- Reaching TIMEOUT acts as GAP.
- If a symbol and the tick that would reach TIMEOUT arrive in the same cycle, the symbol wins and the counter clears.
- With auto_gap_en=0 the counter still runs but has no effect. Raising auto_gap_en while the counter is saturated closes the letter on the next cycle.

On leaving EMIT to IDLE, code_len, code_bits and code_err are cleared to 0.

## Timing

Reset values: code_valid=0, code_len=0, code_bits=0, code_err=0, drop=0, busy=0. State is IDLE and idle_ticks=0.

- clear may be asserted mid-letter or during EMIT. Any pending letter is discarded with no drop pulse.
- Latency: a GAP sampled at edge N gives code_valid=1 after edge N. A timeout tick at edge N gives code_valid=1 after edge N.
- The symbol write is visible on code_bits/code_len at the following edge. Outputs are meaningful only while code_valid=1.
- Handshake: valid is never withdrawn without ready. Data is stable while valid=1 and ready=0. ready may be held high permanently, giving a one-cycle valid pulse per letter.
- drop is asserted in the cycle after the discarded event.
- Throughput: one letter per 2 clk_board cycles minimum (GAP → EMIT → accept).

## Structure

- Shared package morse_pkg holds:
  - the GAP/DOT/DASH/STOP 2-bit constants, also used by the classifier and decoder;
  - the state encoding IDLE=2'b00, COLLECT=2'b01, EMIT=2'b10.
- One sub-module, morse_gap_timer: the tick-driven saturating idle counter. Inputs are clk_board, clear, tick, restart and run; the output is expired.
- The remainder is a single FSM plus the len/bits/err registers.

## Test plan

- DASH, DOT, DOT, GAP with code_ready=1 → code_valid pulse, code_len=3, code_bits=00001 (0b00001), code_err=0, then busy=0.
- 6×DOT, GAP with MAX_SYM=5 → code_len=5, code_bits=00000, code_err=1. No drop.
- DOT, then 8 ticks, auto_gap_en=1 → code_valid after the 8th tick, code_len=1, code_bits=0. Repeat with auto_gap_en=0 → no code_valid.
- DOT, GAP, code_ready=0 for 10 cycles while DASH and GAP arrive → outputs held with code_len=1, drop pulses twice. Then raise code_ready concurrent with DASH → new letter starts with len=1, bit0=1.
- GAP in IDLE → code_valid with code_len=0 (word space). clear asserted mid-COLLECT after 2 symbols → all outputs 0, next letter starts clean.
